// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed, checksummed byte stream and writes it into instruction memory.
// Holds the CPU in reset until the whole image is in memory and the checksum has matched.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          err,
  output logic [2:0]    dbg_state
);

  // Host handshake: a byte moves on a rising edge where in_valid && in_ready.
  // in_ready depends on state only, never on in_valid.
  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CHK, DONE, ERR} state_t;

  state_t        state_q, state_d;
  logic [15:0]   n_q, n_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [7:0]    csum_q, csum_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          xfer;
  logic [15:0]   len;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HDR_HI;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      waddr_q    <= '0;
      csum_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      word_cnt_q <= word_cnt_d;
      byte_idx_q <= byte_idx_d;
      addr_q     <= addr_d;
      waddr_q    <= waddr_d;
      csum_q     <= csum_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    byte_idx_d = byte_idx_q;
    addr_d     = addr_q;
    waddr_d    = waddr_q;
    csum_d     = csum_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    in_ready   = (state_q != DONE) && (state_q != ERR);
    xfer       = in_valid && in_ready;
    len        = {n_q[15:8], in_data};

    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          n_d     = {in_data, 8'h00};
          state_d = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          n_d = len;
          if (len > 16'(DEPTH))   state_d = ERR;
          else if (len == 16'd0) state_d = CHK;
          else                   state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wdata_d    = {wdata_q[23:0], in_data};
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            // wdata_q holds the finished word for the whole pulse cycle,
            // so the memory samples it before the next byte shifts in.
            we_d       = 1'b1;
            waddr_d    = addr_q;
            addr_d     = addr_q + 1'b1;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == n_q - 16'd1) state_d = CHK;
          end
        end
      end
      CHK: begin
        if (xfer) state_d = (in_data == csum_q) ? DONE : ERR;
      end
      default: ;
    endcase
  end

  // The last write pulse always overlaps the CHK cycle, so it lands before cpu_reset falls.
  assign mem_we    = we_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign cpu_reset = (state_q != DONE);
  assign dbg_state = state_q;

endmodule
